// File: rtl/uart_byte_tx.sv
// 8N1 UART byte transmitter with five selectable baud rates; start bit appears one clock after En is accepted.
// No backpressure: En is ignored while busy; Uart_tx_done pulses at frame end so the next byte can be issued.
module uart_byte_tx #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       En,
  input  logic [2:0] Baud_sel,
  input  logic [7:0] Data_byte,
  output logic       Uart_tx,
  output logic       Uart_tx_done,
  output logic       Uart_state
);

  localparam int DIV_9600   = CLK_HZ / 9600   - 1;
  localparam int DIV_19200  = CLK_HZ / 19200  - 1;
  localparam int DIV_38400  = CLK_HZ / 38400  - 1;
  localparam int DIV_57600  = CLK_HZ / 57600  - 1;
  localparam int DIV_115200 = CLK_HZ / 115200 - 1;
  // The slowest rate has the largest divisor, so it sets the counter width.
  localparam int CW = (DIV_9600 > 0) ? $clog2(DIV_9600 + 1) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] div_q, div_d;
  logic [CW-1:0] sel_div;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic [9:0]    frame_bits;
  logic          tx_d, done_d;
  logic          accept, bit_end, frame_end;

  always_comb begin
    case (Baud_sel)
      3'd1:    sel_div = CW'(DIV_19200);
      3'd2:    sel_div = CW'(DIV_38400);
      3'd3:    sel_div = CW'(DIV_57600);
      3'd4:    sel_div = CW'(DIV_115200);
      default: sel_div = CW'(DIV_9600);
    endcase
  end

  assign accept    = (state_q == IDLE) && En;
  assign bit_end   = (state_q == SEND) && (cnt_q == div_q);
  assign frame_end = bit_end && (bit_q == 4'd9);

  // State register
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (En) state_d = SEND;
      SEND:    if (frame_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Divider, bit index and latched byte/divisor
  always_comb begin
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    data_d = data_q;
    div_d  = div_q;
    if (accept) begin
      cnt_d  = '0;
      bit_d  = 4'd0;
      data_d = Data_byte;
      div_d  = sel_div;
    end else if (state_q == SEND) begin
      if (frame_end) begin
        cnt_d = '0;
        bit_d = 4'd0;
      end else if (bit_end) begin
        cnt_d = '0;
        bit_d = bit_q + 4'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      cnt_q  <= '0;
      bit_q  <= 4'd0;
      data_q <= 8'h00;
      div_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      data_q <= data_d;
      div_q  <= div_d;
    end
  end

  // Output logic: computed from next-cycle values so the line itself is a flop.
  always_comb begin
    frame_bits = {1'b1, data_d, 1'b0};
    tx_d       = 1'b1;
    done_d     = frame_end;
    if (state_d == SEND) begin
      tx_d = frame_bits[bit_d];
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Uart_tx      <= 1'b1;
      Uart_tx_done <= 1'b0;
    end else begin
      Uart_tx      <= tx_d;
      Uart_tx_done <= done_d;
    end
  end

  assign Uart_state = (state_q == SEND);

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx at 50 MHz: frame shape, bit timing, busy/done behaviour, mid-frame En and reset.
module tb_uart_byte_tx;

  logic       Clk;
  logic       Rst_n;
  logic       En;
  logic [2:0] Baud_sel;
  logic [7:0] Data_byte;
  logic       Uart_tx;
  logic       Uart_tx_done;
  logic       Uart_state;

  int errors = 0;
  int checks = 0;

  uart_byte_tx #(.CLK_HZ(50_000_000)) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .En           (En),
    .Baud_sel     (Baud_sel),
    .Data_byte    (Data_byte),
    .Uart_tx      (Uart_tx),
    .Uart_tx_done (Uart_tx_done),
    .Uart_state   (Uart_state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Line must stay idle (tx=1, busy=0, no done) for n cycles.
  task automatic idle_wait(input int n, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (Uart_tx !== 1'b1 || Uart_state !== 1'b0 || Uart_tx_done !== 1'b0) bad++;
      tick();
    end
    check(tag, bad, 0);
  endtask

  // Sends one byte and checks every bit for P cycles; exp_bits[k] is the hand-written frame bit k.
  // With poke set, En is re-pulsed and Data_byte/Baud_sel are changed during data bit 3.
  task automatic send_frame(input logic [7:0] b, input logic [2:0] sel, input int P,
                            input logic [9:0] exp_bits, input bit poke, input string tag);
    int bad_ctl;
    int hits;
    Data_byte = b;
    Baud_sel  = sel;
    En        = 1'b1;
    tick();
    En = 1'b0;
    check($sformatf("%s start_tx", tag), Uart_tx, 1'b0);
    check($sformatf("%s start_busy", tag), Uart_state, 1'b1);
    bad_ctl = 0;
    for (int k = 0; k < 10; k++) begin
      hits = 0;
      for (int c = 0; c < P; c++) begin
        if (Uart_tx === exp_bits[k]) hits++;
        if (Uart_state !== 1'b1 || Uart_tx_done !== 1'b0) bad_ctl++;
        if (poke && k == 4 && c == 10) begin
          En        = 1'b1;
          Data_byte = ~b;
          Baud_sel  = 3'd4;
        end else begin
          En = 1'b0;
        end
        tick();
      end
      check($sformatf("%s bit%0d_cycles", tag, k), hits, P);
    end
    check($sformatf("%s busy_done_during_frame", tag), bad_ctl, 0);
    check($sformatf("%s done_pulse", tag), Uart_tx_done, 1'b1);
    check($sformatf("%s busy_end", tag), Uart_state, 1'b0);
    check($sformatf("%s tx_end", tag), Uart_tx, 1'b1);
    tick();
    check($sformatf("%s done_one_cycle", tag), Uart_tx_done, 1'b0);
    check($sformatf("%s idle_after", tag), Uart_state, 1'b0);
  endtask

  initial begin
    int bad;
    Rst_n     = 1'b0;
    En        = 1'b0;
    Baud_sel  = 3'd0;
    Data_byte = 8'h00;

    // Reset held for 10 cycles, outputs idle throughout and afterwards.
    tick();
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      if (Uart_tx !== 1'b1 || Uart_state !== 1'b0 || Uart_tx_done !== 1'b0) bad++;
      tick();
    end
    check("reset_hold", bad, 0);
    Rst_n = 1'b1;
    idle_wait(20, "post_reset_idle");

    // 115200 baud: P = 434 clocks per bit.
    send_frame(8'hFE, 3'd4, 434, 10'b1_11111110_0, 1'b0, "fe");
    idle_wait(150, "gap1");
    send_frame(8'hAA, 3'd4, 434, 10'b1_10101010_0, 1'b0, "aa");
    idle_wait(150, "gap2");
    send_frame(8'h55, 3'd4, 434, 10'b1_01010101_0, 1'b0, "55");
    idle_wait(150, "gap3");

    // 9600 baud: P = 5208; mid-frame En, data and baud changes must be ignored.
    send_frame(8'h00, 3'd0, 5208, 10'b1_00000000_0, 1'b1, "sel0");
    Data_byte = 8'h00;
    idle_wait(50, "gap4");

    // Reset during data bit 3 (frame bit 4) of 8'hA5, whose bit 3 is 0.
    Data_byte = 8'hA5;
    Baud_sel  = 3'd4;
    En        = 1'b1;
    tick();
    En = 1'b0;
    for (int i = 0; i < 4 * 434 + 100; i++) tick();
    check("abort_pre_tx", Uart_tx, 1'b0);
    check("abort_pre_busy", Uart_state, 1'b1);
    Rst_n = 1'b0;
    tick();
    check("abort_tx", Uart_tx, 1'b1);
    check("abort_busy", Uart_state, 1'b0);
    check("abort_done", Uart_tx_done, 1'b0);
    Rst_n = 1'b1;
    idle_wait(500, "abort_quiet");

    send_frame(8'h3C, 3'd4, 434, 10'b1_00111100_0, 1'b0, "fresh");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
